// File: rtl/tdm_pkg.sv
// Shared constants and types for the TDM receive demultiplexer.
// Defining TDM_PARITY_EN appends one even-parity slot to every frame.
package tdm_pkg;

    localparam int DEF_NUM_CH = 16;
    localparam int DEF_SEL_W  = 4;

`ifdef TDM_PARITY_EN
    localparam int PAR_SLOTS = 1;
`else
    localparam int PAR_SLOTS = 0;
`endif

    localparam int FRAME_LEN = DEF_NUM_CH + PAR_SLOTS;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_slot_decoder.sv
// Turns the current slot index into a one-hot shadow-register write enable.
// Indices at or beyond NUM_CH (the parity slot) enable nothing.
module tdm_slot_decoder
    import tdm_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_SEL_W
) (
    input  logic [CNT_W-1:0]  i_slot,
    input  logic              i_beat,
    output logic [NUM_CH-1:0] o_we
);

    always_comb begin
        o_we = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (i_beat && (i_slot == CNT_W'(k))) begin
                o_we[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdm_demux16.sv
// TDM serial-to-parallel receiver: frame-lock FSM, slot counter and shadow register.
// Build with TDM_PARITY_EN to add a trailing parity slot and the parity_err output.
module tdm_demux16
    import tdm_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = DEF_SEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              din_valid,
    input  logic              frame_sync,
    output logic [NUM_CH-1:0] data_out,
    output logic              frame_valid,
    output logic [SEL_W-1:0]  slot,
    output logic              locked,
    output logic              sync_err
`ifdef TDM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int CNT_W = SEL_W + PAR_SLOTS;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CH + PAR_SLOTS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_slot;
    logic [CNT_W-1:0]   w_slot_nxt;
    logic [CNT_W-1:0]   w_wr_idx;
    logic               w_wr_en;
    logic               w_publish;
    logic               w_err;
    logic [NUM_CH-1:0]  w_we;
    logic [NUM_CH-1:0]  w_frame;
    logic [NUM_CH-1:0]  r_shadow;
    logic [NUM_CH-1:0]  r_data;
    logic               r_fv;
    logic               r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_wr_idx    = r_slot;
        w_wr_en     = 1'b0;
        w_publish   = 1'b0;
        w_err       = 1'b0;
        if (din_valid) begin
            unique case (r_state)
                HUNT: begin
                    if (frame_sync) begin
                        w_wr_idx    = '0;
                        w_wr_en     = 1'b1;
                        w_slot_nxt  = CNT_W'(1);
                        w_state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if ((r_slot == '0) && !frame_sync) begin
                        w_err       = 1'b1;
                        w_state_nxt = HUNT;
                    end else if ((r_slot != '0) && frame_sync) begin
                        // Early sync restarts the frame on this beat.
                        w_err      = 1'b1;
                        w_wr_idx   = '0;
                        w_wr_en    = 1'b1;
                        w_slot_nxt = CNT_W'(1);
                    end else begin
                        w_wr_en = 1'b1;
                        if (r_slot == LAST) begin
                            w_publish  = 1'b1;
                            w_slot_nxt = '0;
                        end else begin
                            w_slot_nxt = r_slot + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    tdm_slot_decoder #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) u_dec (
        .i_slot (w_wr_idx),
        .i_beat (w_wr_en),
        .o_we   (w_we)
    );

`ifdef TDM_PARITY_EN
    logic r_perr;
    assign w_frame = r_shadow;
`else
    assign w_frame = {din, r_shadow[NUM_CH-2:0]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= HUNT;
            r_slot   <= '0;
            r_shadow <= '0;
            r_data   <= '0;
            r_fv     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_slot   <= w_slot_nxt;
            r_shadow <= (r_shadow & ~w_we) | (w_we & {NUM_CH{din}});
            r_fv     <= w_publish;
            r_err    <= w_err;
            if (w_publish) begin
                r_data <= w_frame;
            end
        end
    end

`ifdef TDM_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_publish & (^{r_shadow, din});
        end
    end
    assign parity_err = r_perr;
`endif

    assign data_out    = r_data;
    assign frame_valid = r_fv;
    assign slot        = r_slot[SEL_W-1:0];
    assign locked      = (r_state == LOCKED);
    assign sync_err    = r_err;

endmodule

// File: tb/tb_tdm_demux16.sv
// Directed bench for tdm_demux16 with a queue-based scoreboard.
// Frame and sync_err expectations are queued by stimulus and popped by a monitor.
module tb_tdm_demux16;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         din = 1'b0;
    logic         din_valid = 1'b0;
    logic         frame_sync = 1'b0;
    logic [N-1:0] data_out;
    logic         frame_valid;
    logic [3:0]   slot;
    logic         locked;
    logic         sync_err;
`ifdef TDM_PARITY_EN
    logic         parity_err;
`endif

    typedef struct {
        logic [N-1:0] d;
        logic         pe;
        int           cyc;
    } exp_t;

    exp_t fq[$];
    int   sq[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t m_e;
    int   m_c;

    tdm_demux16 dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .data_out    (data_out),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
`ifdef TDM_PARITY_EN
        .parity_err  (parity_err),
`endif
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (frame_valid !== 1'b0) begin
            if (fq.size() == 0) begin
                check("unexpected frame_valid", 32'(frame_valid), 32'd0);
            end else begin
                m_e = fq.pop_front();
                check("frame data", 32'(data_out), 32'(m_e.d));
                check("frame latency cycle", 32'(cyc), 32'(m_e.cyc));
`ifdef TDM_PARITY_EN
                check("parity_err", 32'(parity_err), 32'(m_e.pe));
`endif
            end
        end
        if (sync_err !== 1'b0) begin
            if (sq.size() == 0) begin
                check("unexpected sync_err", 32'(sync_err), 32'd0);
            end else begin
                m_c = sq.pop_front();
                check("sync_err cycle", 32'(cyc), 32'(m_c));
            end
        end
    end

    task automatic beat(input logic d, input logic fs);
        din        = d;
        frame_sync = fs;
        din_valid  = 1'b1;
        @(posedge clk);
        #1;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        din        = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [N-1:0] d, input int gap,
                              input logic inj);
        for (int k = 0; k < N; k++) begin
            beat(d[k], k == 0);
            if (gap > 0 && k < N - 1) begin
                idle(gap);
                if (k == 5) check("slot holds in gap", 32'(slot), 32'd6);
            end
        end
`ifdef TDM_PARITY_EN
        if (gap > 0) idle(gap);
        beat((^d) ^ inj, 1'b0);
        fq.push_back('{d, inj, cyc});
`else
        fq.push_back('{d, 1'b0, cyc});
`endif
    endtask

    initial begin
        logic [N-1:0] pat;

        // 1: reset and hunt
        @(posedge clk);
        #1;
        check("reset data_out", 32'(data_out), 32'd0);
        check("reset locked", 32'(locked), 32'd0);
        check("reset slot", 32'(slot), 32'd0);
        check("reset frame_valid", 32'(frame_valid), 32'd0);
        rst = 1'b0;
        idle(1);
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b0);
        check("hunt locked", 32'(locked), 32'd0);
        check("hunt slot", 32'(slot), 32'd0);
        check("hunt data_out", 32'(data_out), 32'd0);

        // 2: clean frame
        send_frame(16'hA5C3, 0, 1'b0);
        check("locked after frame", 32'(locked), 32'd1);
        check("slot wraps", 32'(slot), 32'd0);
        idle(2);
        check("data_out held", 32'(data_out), 32'hA5C3);

        // 3: gapped frame
        send_frame(16'hA5C3, 1, 1'b0);
        idle(2);

        // 4: early sync at slot 7
        pat = 16'h00FF;
        for (int k = 0; k < 7; k++) beat(pat[k], k == 0);
        check("partial slot", 32'(slot), 32'd7);
        sq.push_back(cyc + 1);
        send_frame(16'h1234, 0, 1'b0);
        idle(2);
        check("after resync data_out", 32'(data_out), 32'h1234);

        // 5: missing sync
        send_frame(16'h5A5A, 0, 1'b0);
        sq.push_back(cyc + 1);
        beat(1'b1, 1'b0);
        check("missing sync locked", 32'(locked), 32'd0);
        check("missing sync data_out", 32'(data_out), 32'h5A5A);
        for (int i = 0; i < 3; i++) beat(1'b0, 1'b0);
        check("still hunting", 32'(locked), 32'd0);

        // 6: reset mid-frame
        pat = 16'h0F0F;
        for (int k = 0; k < 9; k++) beat(pat[k], k == 0);
        check("mid-frame slot", 32'(slot), 32'd9);
        rst = 1'b1;
        #1;
        check("mid reset data_out", 32'(data_out), 32'd0);
        check("mid reset locked", 32'(locked), 32'd0);
        check("mid reset slot", 32'(slot), 32'd0);
        idle(2);
        rst = 1'b0;
        idle(1);
        send_frame(16'hFFFF, 0, 1'b0);
`ifdef TDM_PARITY_EN
        send_frame(16'h0001, 0, 1'b1);
`endif
        idle(3);
        check("frames outstanding", 32'(fq.size()), 32'd0);
        check("sync_err outstanding", 32'(sq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
